// File: rtl/arb_mux.sv
`default_nettype none
// ============================================================================
//  Module   : arb_mux
//  Purpose  : Registered N-channel arbitrating multiplexer. One channel is
//             granted per cycle by round-robin, fixed priority (lowest index)
//             or an explicit forced select; the winning word and its source
//             index are captured in a single output register.
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             rr_mode         - 1 = round-robin, 0 = fixed priority
//             force_en/sel    - override arbitration with a channel index
//             in_valid/ready  - per-channel handshake (ready one-hot or zero)
//             in_data         - channel i at bits [i*WIDTH +: WIDTH]
//             out_valid/ready - output handshake
//             out_data/sel    - held beat and the channel it came from
//  Revision : 1.0 - initial release
// ============================================================================
module arb_mux #(
   parameter int WIDTH    = 32,
   parameter int CHANNELS = 9,
   parameter int SELW     = $clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      rr_mode,
   input  logic                      force_en,
   input  logic [SELW-1:0]           force_sel,
   input  logic [CHANNELS-1:0]       in_valid,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   output logic [CHANNELS-1:0]       in_ready,
   output logic                      out_valid,
   output logic [WIDTH-1:0]          out_data,
   output logic [SELW-1:0]           out_sel,
   input  logic                      out_ready
);

   localparam logic [SELW:0]   C_NCH  = (SELW+1)'(CHANNELS);
   localparam logic [SELW-1:0] C_LAST = SELW'(CHANNELS-1);

   logic [WIDTH-1:0] ch_data [CHANNELS];

   logic [SELW-1:0]  ptr_q, ptr_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [SELW-1:0]  out_sel_q, out_sel_d;

   logic             grant_vld;
   logic [SELW-1:0]  grant_idx;
   logic [SELW:0]    rr_sum;
   logic [SELW-1:0]  scan_idx;
   logic             space;
   logic             accept;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_unpack
      assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
   end

   // Grant selection. The scan visits channels in priority order and keeps
   // the first valid one; in round-robin mode the order starts at ptr_q.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      rr_sum    = '0;
      scan_idx  = '0;
      if (force_en) begin
         // Out-of-range indices never grant, so the valid lookup is masked.
         if (({1'b0, force_sel} < C_NCH) && in_valid[force_sel]) begin
            grant_vld = 1'b1;
            grant_idx = force_sel;
         end
      end else begin
         for (int k = 0; k < CHANNELS; k++) begin
            rr_sum = {1'b0, ptr_q} + (SELW+1)'(k);
            if (rr_sum >= C_NCH) begin
               rr_sum = rr_sum - C_NCH;
            end
            scan_idx = rr_mode ? rr_sum[SELW-1:0] : SELW'(k);
            if (!grant_vld && in_valid[scan_idx]) begin
               grant_vld = 1'b1;
               grant_idx = scan_idx;
            end
         end
      end
   end

   // Handshake and next-state. A draining beat frees the register in the
   // same cycle, so a refill needs no bubble.
   always_comb begin
      space       = !out_valid_q || out_ready;
      accept      = grant_vld && space && !rst;
      in_ready    = '0;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      ptr_d       = ptr_q;
      if (accept) begin
         in_ready[grant_idx] = 1'b1;
         out_valid_d         = 1'b1;
         out_data_d          = ch_data[grant_idx];
         out_sel_d           = grant_idx;
         if (!force_en && rr_mode) begin
            ptr_d = (grant_idx == C_LAST) ? '0 : grant_idx + 1'b1;
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
      end else begin
         ptr_q       <= ptr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;

endmodule
`default_nettype wire

// File: tb/tb_arb_mux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_arb_mux
//  Purpose  : Self-checking bench for arb_mux: table vectors, hand-written
//             corner sequences and random stimulus against a reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_arb_mux;

   localparam int W   = 32;
   localparam int NCH = 9;
   localparam int SW  = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              rr_mode;
   logic              force_en;
   logic [SW-1:0]     force_sel;
   logic [NCH-1:0]    in_valid;
   logic [NCH*W-1:0]  in_data;
   logic [NCH-1:0]    in_ready;
   logic              out_valid;
   logic [W-1:0]      out_data;
   logic [SW-1:0]     out_sel;
   logic              out_ready;

   int checks   = 0;
   int failures = 0;

   // Reference model state: what the output register should hold.
   int         m_ptr = 0;
   bit         m_ov  = 1'b0;
   logic [W-1:0] m_od = '0;
   int         m_os  = 0;

   typedef struct {
      logic          rst;
      logic          rr;
      logic          fe;
      logic [3:0]    fsel;
      logic [8:0]    vld;
      logic          ordy;
      logic [8:0]    e_rdy;
      logic          e_ov;
      logic [3:0]    e_sel;
      logic [31:0]   e_data;
   } vec_t;

   vec_t tbl [17];

   always #5 clk = ~clk;

   arb_mux #(.WIDTH(W), .CHANNELS(NCH)) dut (
      .clk       (clk),
      .rst       (rst),
      .rr_mode   (rr_mode),
      .force_en  (force_en),
      .force_sel (force_sel),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_ready (out_ready)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [W-1:0] chdata(input int i);
      return in_data[i*W +: W];
   endfunction

   // Grant chosen by the arbitration rules; -1 means no grant.
   function automatic int ref_grant();
      if (force_en) begin
         if (int'(force_sel) < NCH && in_valid[force_sel]) return int'(force_sel);
         return -1;
      end
      for (int k = 0; k < NCH; k++) begin
         int c;
         c = rr_mode ? (m_ptr + k) % NCH : k;
         if (in_valid[c]) return c;
      end
      return -1;
   endfunction

   task automatic drive(input logic r, input logic rr, input logic fe,
                        input logic [3:0] fs, input logic [8:0] v, input logic ordy);
      rst       = r;
      rr_mode   = rr;
      force_en  = fe;
      force_sel = fs;
      in_valid  = v;
      out_ready = ordy;
   endtask

   task automatic set_fixed_data();
      for (int i = 0; i < NCH; i++) in_data[i*W +: W] = 32'(256 + i);
   endtask

   // One clock: check in_ready mid-cycle, advance the model at the edge,
   // check the registered outputs just after it.
   task automatic step(input bit use_tbl, input logic [NCH-1:0] t_rdy, input logic t_ov,
                       input logic [SW-1:0] t_sel, input logic [W-1:0] t_data);
      int g;
      bit acc;
      logic [NCH-1:0] e_rdy;
      @(negedge clk);
      g     = ref_grant();
      acc   = (g >= 0) && (!m_ov || out_ready) && !rst;
      e_rdy = '0;
      if (acc) e_rdy[g] = 1'b1;
      chk("in_ready_model", 64'(in_ready), 64'(e_rdy));
      if (use_tbl) chk("in_ready_vec", 64'(in_ready), 64'(t_rdy));
      @(posedge clk);
      if (rst) begin
         m_ov = 1'b0; m_od = '0; m_os = 0; m_ptr = 0;
      end else if (acc) begin
         m_ov = 1'b1;
         m_od = chdata(g);
         m_os = g;
         if (!force_en && rr_mode) m_ptr = (g + 1) % NCH;
      end else if (out_ready) begin
         m_ov = 1'b0;
      end
      #1;
      chk("out_valid_model", 64'(out_valid), 64'(m_ov));
      chk("out_data_model",  64'(out_data),  64'(m_od));
      chk("out_sel_model",   64'(out_sel),   64'(m_os));
      if (use_tbl) begin
         chk("out_valid_vec", 64'(out_valid), 64'(t_ov));
         chk("out_data_vec",  64'(out_data),  64'(t_data));
         chk("out_sel_vec",   64'(out_sel),   64'(t_sel));
      end
   endtask

   initial begin
      tbl[0]  = '{1'b0,1'b1,1'b0,4'd0, 9'h1FF,1'b1, 9'h001,1'b1,4'd0,32'h100};
      tbl[1]  = '{1'b0,1'b1,1'b0,4'd0, 9'h1FF,1'b1, 9'h002,1'b1,4'd1,32'h101};
      tbl[2]  = '{1'b0,1'b0,1'b0,4'd0, 9'h124,1'b1, 9'h004,1'b1,4'd2,32'h102};
      tbl[3]  = '{1'b0,1'b0,1'b0,4'd0, 9'h124,1'b1, 9'h004,1'b1,4'd2,32'h102};
      tbl[4]  = '{1'b0,1'b1,1'b0,4'd0, 9'h124,1'b1, 9'h004,1'b1,4'd2,32'h102};
      tbl[5]  = '{1'b0,1'b1,1'b0,4'd0, 9'h124,1'b1, 9'h020,1'b1,4'd5,32'h105};
      tbl[6]  = '{1'b0,1'b1,1'b0,4'd0, 9'h124,1'b1, 9'h100,1'b1,4'd8,32'h108};
      tbl[7]  = '{1'b0,1'b1,1'b0,4'd0, 9'h124,1'b1, 9'h004,1'b1,4'd2,32'h102};
      tbl[8]  = '{1'b0,1'b1,1'b1,4'd7, 9'h1FF,1'b1, 9'h080,1'b1,4'd7,32'h107};
      tbl[9]  = '{1'b0,1'b1,1'b1,4'd7, 9'h07F,1'b1, 9'h000,1'b0,4'd7,32'h107};
      tbl[10] = '{1'b0,1'b1,1'b1,4'd9, 9'h1FF,1'b1, 9'h000,1'b0,4'd7,32'h107};
      tbl[11] = '{1'b0,1'b1,1'b0,4'd0, 9'h1FF,1'b0, 9'h008,1'b1,4'd3,32'h103};
      tbl[12] = '{1'b0,1'b1,1'b0,4'd0, 9'h1FF,1'b0, 9'h000,1'b1,4'd3,32'h103};
      tbl[13] = '{1'b0,1'b1,1'b0,4'd0, 9'h1FF,1'b1, 9'h010,1'b1,4'd4,32'h104};
      tbl[14] = '{1'b0,1'b1,1'b1,4'd15,9'h1FF,1'b1, 9'h000,1'b0,4'd4,32'h104};
      tbl[15] = '{1'b1,1'b1,1'b0,4'd0, 9'h1FF,1'b1, 9'h000,1'b0,4'd0,32'h000};
      tbl[16] = '{1'b0,1'b1,1'b0,4'd0, 9'h1FF,1'b1, 9'h001,1'b1,4'd0,32'h100};

      set_fixed_data();

      // Reset held two cycles with everything valid: nothing may be ready.
      drive(1'b1, 1'b1, 1'b0, 4'd0, 9'h1FF, 1'b1);
      step(1'b1, 9'h000, 1'b0, 4'd0, 32'h0);
      step(1'b1, 9'h000, 1'b0, 4'd0, 32'h0);

      // Vector table: rr start, fixed priority, rr skip/wrap, forced modes,
      // backpressure, out-of-range select, reset, restart from channel 0.
      for (int i = 0; i < 17; i++) begin
         drive(tbl[i].rst, tbl[i].rr, tbl[i].fe, tbl[i].fsel, tbl[i].vld, tbl[i].ordy);
         step(1'b1, tbl[i].e_rdy, tbl[i].e_ov, tbl[i].e_sel, tbl[i].e_data);
      end

      // Round-robin fairness: 0..8,0 on consecutive cycles, no bubbles.
      drive(1'b1, 1'b1, 1'b0, 4'd0, 9'h1FF, 1'b1);
      step(1'b1, 9'h000, 1'b0, 4'd0, 32'h0);
      for (int k = 0; k < 10; k++) begin
         logic [8:0] r;
         r = 9'b1 << (k % NCH);
         drive(1'b0, 1'b1, 1'b0, 4'd0, 9'h1FF, 1'b1);
         step(1'b1, r, 1'b1, 4'(k % NCH), 32'(256 + (k % NCH)));
      end

      // Backpressure with pointer wrap: ptr to 8, hold channel 8 for three
      // cycles, then channel 0 loads on the draining edge.
      drive(1'b1, 1'b1, 1'b0, 4'd0, 9'h1FF, 1'b1);
      step(1'b1, 9'h000, 1'b0, 4'd0, 32'h0);
      drive(1'b0, 1'b1, 1'b0, 4'd0, 9'h080, 1'b1);
      step(1'b1, 9'h080, 1'b1, 4'd7, 32'h107);
      drive(1'b0, 1'b1, 1'b0, 4'd0, 9'h101, 1'b1);
      step(1'b1, 9'h100, 1'b1, 4'd8, 32'h108);
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 1'b1, 1'b0, 4'd0, 9'h101, 1'b0);
         step(1'b1, 9'h000, 1'b1, 4'd8, 32'h108);
      end
      drive(1'b0, 1'b1, 1'b0, 4'd0, 9'h101, 1'b1);
      step(1'b1, 9'h001, 1'b1, 4'd0, 32'h100);

      // Reset while channel 4's beat is stalled: beat discarded, ptr at 0.
      drive(1'b1, 1'b1, 1'b0, 4'd0, 9'h1FF, 1'b1);
      step(1'b1, 9'h000, 1'b0, 4'd0, 32'h0);
      drive(1'b0, 1'b0, 1'b0, 4'd0, 9'h010, 1'b0);
      step(1'b1, 9'h010, 1'b1, 4'd4, 32'h104);
      step(1'b1, 9'h000, 1'b1, 4'd4, 32'h104);
      drive(1'b1, 1'b0, 1'b0, 4'd0, 9'h010, 1'b0);
      step(1'b1, 9'h000, 1'b0, 4'd0, 32'h0);
      drive(1'b0, 1'b0, 1'b0, 4'd0, 9'h000, 1'b0);
      step(1'b1, 9'h000, 1'b0, 4'd0, 32'h0);
      drive(1'b0, 1'b1, 1'b0, 4'd0, 9'h1FF, 1'b1);
      step(1'b1, 9'h001, 1'b1, 4'd0, 32'h100);

      // Random traffic against the reference model.
      for (int n = 0; n < 1500; n++) begin
         for (int i = 0; i < NCH; i++) in_data[i*W +: W] = $urandom();
         drive(($urandom_range(0, 39) == 0),
               1'($urandom_range(0, 1)),
               ($urandom_range(0, 4) == 0),
               4'($urandom_range(0, 15)),
               9'($urandom()),
               ($urandom_range(0, 3) != 0));
         step(1'b0, '0, 1'b0, '0, '0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
